// File: rtl/tdm_demux_4ch_pkg.sv
// Shared constants and types for the 4-channel TDM demultiplexer.
//   NCH    : channels per frame (fixed at 4)
//   SEL_W  : slot index width
//   state_e: framing FSM states (HUNT = searching for sync, RUN = aligned)
package tdm_demux_4ch_pkg;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/tdm_demux_4ch_if.sv
// Serial-in / parallel-out bundle for tdm_demux_4ch.
//   din, din_valid, frame_sync : serial TDM stream (driven by link side)
//   ch_data, ch_valid          : per-channel words and update pulses
//   sel, locked, frame_done, sync_err : framing status
// slave  = demux side, master = stream source / consumer side.
interface tdm_demux_4ch_if #(parameter int W = 8);
  import tdm_demux_4ch_pkg::*;

  logic               din;
  logic               din_valid;
  logic               frame_sync;
  logic [NCH*W-1:0]   ch_data;
  logic [NCH-1:0]     ch_valid;
  sel_t               sel;
  logic               locked;
  logic               frame_done;
  logic               sync_err;

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, ch_valid, sel, locked, frame_done, sync_err
  );

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, ch_valid, sel, locked, frame_done, sync_err
  );
endinterface

// File: rtl/tdm_demux_4ch_slot_shifter.sv
// tdm_slot_shifter: MSB-first slot deserialiser with bit counter.
//   clk, rst_n : clock, async active-low reset
//   shift_en   : shift din in and advance the bit counter
//   restart    : din becomes bit 0 of a new slot (counter -> 1)
//   din        : serial bit
//   word       : completed word if the current din is the slot's last bit
//   last       : current din is the last bit of the slot
//   at_start   : no bits of the current slot collected yet
module tdm_slot_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         restart,
  input  logic         din,
  output logic [W-1:0] word,
  output logic         last,
  output logic         at_start
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  // Only W-1 bits are stored; the final bit is taken straight from din so
  // the word can be registered on the same edge that samples it.
  logic [W-2:0]  shift_q;
  logic [CW-1:0] bitcnt_q;

  assign word     = {shift_q, din};
  assign last     = (bitcnt_q == LAST_CNT);
  assign at_start = (bitcnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else if (restart) begin
      shift_q    <= '0;
      shift_q[0] <= din;
      bitcnt_q   <= CW'(1);
    end else if (shift_en) begin
      shift_q  <= word[W-2:0];
      bitcnt_q <= last ? '0 : bitcnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive side of a 4-slot TDM link. Locks to frame_sync,
// deserialises each W-bit slot and writes it into the matching channel
// register with a one-cycle ch_valid pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : tdm_demux_4ch_if.slave (serial in, channel words/status out)
module tdm_demux_4ch
  import tdm_demux_4ch_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tdm_demux_4ch_if.slave         bus
);
  state_e                  state_q;
  sel_t                    sel_q;
  logic [NCH-1:0][W-1:0]   ch_q;
  logic [NCH-1:0]          ch_valid_q;
  logic                    locked_q, frame_done_q, sync_err_q;

  logic [W-1:0] word;
  logic         last, at_start;
  logic         sample, boundary, resync, restart, shift_en;

  assign sample   = bus.din_valid;
  assign boundary = (sel_q == '0) && at_start;
  // Sync anywhere but the frame boundary while running realigns the frame.
  assign resync   = sample && bus.frame_sync && (state_q == RUN) && !boundary;
  // Sync on the boundary needs no restart: a normal shift gives the same result.
  assign restart  = sample && bus.frame_sync && ((state_q == HUNT) || !boundary);
  assign shift_en = sample && (state_q == RUN) && !resync;

  tdm_slot_shifter #(.W(W)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .restart  (restart),
    .din      (bus.din),
    .word     (word),
    .last     (last),
    .at_start (at_start)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      sel_q        <= '0;
      ch_q         <= '0;
      ch_valid_q   <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (sample) begin
        if (state_q == HUNT) begin
          if (bus.frame_sync) begin
            state_q  <= RUN;
            locked_q <= 1'b1;
            sel_q    <= '0;
          end
        end else if (resync) begin
          // Partial slot is dropped; resync beats a coincident last bit.
          sync_err_q <= 1'b1;
          sel_q      <= '0;
        end else if (last) begin
          ch_q[sel_q]       <= word;
          ch_valid_q[sel_q] <= 1'b1;
          sel_q             <= sel_q + 1'b1;
          frame_done_q      <= (sel_q == SEL_W'(NCH - 1));
        end
      end
    end
  end

  assign bus.ch_data    = ch_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.sel        = sel_q;
  assign bus.locked     = locked_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: doc/tdm_demux_4ch.md
Name: tdm_demux_4ch

Overview:
- Receive-side counterpart of the 4:1 channel multiplexer: accepts a serial time-division-multiplexed bit stream carrying four channel slots per frame.
- Tracks the slot position with a slot counter, deserialises each slot into a W-bit word and routes it to the matching channel register.
- Sits at the far end of the serial link, feeding per-channel consumers.
- Frame alignment comes from a single-cycle frame_sync marker on the first bit of slot 0.

Parameters:
- W, 8, bits per channel slot (≥2).
- NCH, 4, channels per frame (fixed at 4; slot index is 2 bits).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit, MSB of each slot first.
- din_valid  input  1  qualifies din/frame_sync. Counters hold when low.
- frame_sync  input  1  high with din_valid on bit 0 of slot 0.
- ch_data  output  4*W  channel words; channel k at [k*W +: W].
- ch_valid  output  4  one-cycle pulse per channel when its word updates.
- sel  output  2  slot index of the next bit expected.
- locked  output  1  high while aligned to a frame.
- frame_done  output  1  one-cycle pulse when slot 3 completes.
- sync_err  output  1  one-cycle pulse on misplaced frame_sync.

Behaviour:
- Reset (async assert, sync release) clears all of the following:
  - ch_data=0, ch_valid=0, sel=0, locked=0, frame_done=0, sync_err=0.
  - Shift register, bit counter and state, with state=HUNT.
- Sample event: rising clk with din_valid=1. When din_valid=0, nothing advances, and ch_valid, frame_done and sync_err deassert.
- HUNT state:
  - Ignore din until a sample with frame_sync=1.
  - That bit becomes bit 0 of slot 0: shift it in, bitcnt=1, sel=0, locked=1, go to RUN.
- RUN state:
  - Each sample shifts din into the LSB of the shift register (MSB-first assembly) and increments bitcnt.
  - On the sample where bitcnt==W-1 (last bit of the slot), on the next clock:
    - ch_data[sel] = {shift[W-2:0], din}.
    - ch_valid[sel] pulses for one cycle.
    - bitcnt=0 and sel increments mod 4 (3 wraps to 0).
    - If sel was 3, frame_done pulses in the same cycle.
  - Latency: word visible and ch_valid high one clock after its last bit is sampled.
- Alignment rules:
  - frame_sync on the expected frame boundary (sel==0, bitcnt==0 in RUN) is normal, with no error.
  - Absent frame_sync at the boundary: keep running freewheel, with no error.
  - frame_sync at any other position in RUN:
    - sync_err pulses.
    - The partial word is discarded, and ch_data is not written for the interrupted slot.
    - The sync bit becomes bit 0 of slot 0 (bitcnt=1, sel=0). Stay in RUN and locked.
- Simultaneous events:
  - Misplaced sync on what would be a slot's last bit: the resync wins. No ch_valid, no frame_done.
  - frame_sync with din_valid=0 is ignored.
- Reset mid-frame: everything clears immediately, and the block returns to HUNT. The partial word is lost.
- ch_data holds its last written value between updates.
- At most one ch_valid bit is high in any cycle.

Decomposition:
- Shared package/header constants:
  - NCH=4 and the slot index width 2.
  - State encodings HUNT/RUN.
- One natural sub-module: tdm_slot_shifter. It holds the W-bit shift register plus bitcnt and flags the last bit of a slot.
- The top level holds the FSM, the sel counter and the channel register bank.

Test Plan:
- Reset, then sync on the first bit, then a frame with slots 0xA5,0x3C,0xFF,0x01 (W=8), din_valid continuous:
  - ch_valid pulses 1,2,4,8 at 8-cycle spacing, each one clock after the slot's last bit.
  - ch_data = 0x01FF3CA5.
  - frame_done pulses with ch_valid[3].
- Same frame with din_valid low every other cycle: identical ch_data, with pulses spaced 16 cycles apart.
- Two back-to-back frames with sync only on the first: the second frame decodes correctly in freewheel, with no sync_err.
- frame_sync asserted at bit 4 of slot 2:
  - sync_err pulses and no ch_valid[2] occurs.
  - The following 32 bits decode as a fresh frame starting at slot 0.
- Stream bits with no frame_sync after reset: locked=0, and no ch_valid for 64 samples.
- rst_n pulled low mid slot 1: all outputs are 0 asynchronously. After release, the block stays in HUNT until the next sync.
